// File: rtl/memory_bus_initiator_pkg.sv
// Shared memory-bus types: packet layout, source ids and the physical memory limit.
// Also provides the initiator's address range check as a helper.
package memory_bus_initiator_pkg;

  typedef logic [63:0] phys_memory_address_t;
  typedef logic [63:0] bus_packet_payload_t;
  typedef logic [3:0]  source_id_t;

  typedef enum logic {
    bus_read_data  = 1'b0,
    bus_write_data = 1'b1
  } bus_packet_type_t;

  typedef struct packed {
    bus_packet_type_t     packet_type;
    phys_memory_address_t address;
    bus_packet_payload_t  payload;
    source_id_t           source;
  } BusPacket;

  localparam phys_memory_address_t END_MEMORY_ADDRESS = 64'h0000_0000_1000_0000;

  // A full 8-byte access must end at or below END_MEMORY_ADDRESS.
  function automatic logic addr_in_range(input phys_memory_address_t addr);
    return addr <= (END_MEMORY_ADDRESS - 64'd8);
  endfunction

endpackage

// File: rtl/memory_bus_initiator_timeout.sv
// Read-response watchdog: counts waiting cycles and flags the last permitted one.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter; clear has priority over counting
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/memory_bus_initiator.sv
// CPU-side memory bus master: one outstanding load/store, range check,
// response filtering by destination and a sticky read-timeout fault.
module memory_bus_initiator
  import memory_bus_initiator_pkg::*;
#(
  parameter source_id_t SOURCE_ID      = 4'd0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic                 cpu_req_write,
  input  phys_memory_address_t cpu_req_addr,
  input  bus_packet_payload_t  cpu_req_wdata,
  output logic                 cpu_rsp_valid,
  output bus_packet_payload_t  cpu_rsp_rdata,
  output logic                 cpu_rsp_error,
  output logic                 bus_req_valid,
  output BusPacket             bus_req_pkt,
  input  logic                 bus_req_accept,
  input  logic                 bus_rsp_valid,
  input  bus_packet_payload_t  bus_rsp_payload,
  input  source_id_t           bus_rsp_dest
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RSP = 3'd2,
    RESPOND  = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  BusPacket            pkt_r;
  logic                write_r;
  bus_packet_payload_t rdata_r;
  logic                error_r;
  logic                fault_r;

  logic latch_s;
  logic range_err_s;
  logic clear_s;
  logic capture_s;
  logic timeout_s;
  logic expired_s;
  logic rsp_match_s;
  logic rsp_valid_s;

  assign rsp_match_s = bus_rsp_valid && (bus_rsp_dest == SOURCE_ID);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .enable (state_r == WAIT_RSP),
    .expired(expired_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    range_err_s  = 1'b0;
    clear_s      = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req_valid) begin
          latch_s = 1'b1;
          if (addr_in_range(cpu_req_addr)) begin
            state_next_s = ISSUE;
          end else begin
            range_err_s  = 1'b1;
            state_next_s = RESPOND;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus_req_accept) begin
          if (write_r) begin
            state_next_s = RESPOND;
          end else begin
            clear_s      = 1'b1;
            state_next_s = WAIT_RSP;
          end
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAIT_RSP: begin
        // A response landing in the expiry cycle still completes normally
        if (rsp_match_s) begin
          capture_s    = 1'b1;
          state_next_s = RESPOND;
        end else if (expired_s) begin
          timeout_s    = 1'b1;
          state_next_s = RESPOND;
        end else begin
          state_next_s = WAIT_RSP;
        end
      end
      RESPOND: begin
        if (fault_r) begin
          state_next_s = FAULT;
        end else begin
          state_next_s = IDLE;
        end
      end
      FAULT:   state_next_s = FAULT;
      default: state_next_s = IDLE;
    endcase
  end

  // Latched request packet, completion data/error and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_r   <= '0;
      write_r <= 1'b0;
      rdata_r <= 64'd0;
      error_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      if (latch_s) begin
        pkt_r.packet_type <= cpu_req_write ? bus_write_data : bus_read_data;
        pkt_r.address     <= cpu_req_addr;
        pkt_r.payload     <= cpu_req_write ? cpu_req_wdata : 64'd0;
        pkt_r.source      <= SOURCE_ID;
        write_r           <= cpu_req_write;
        rdata_r           <= 64'd0;
        error_r           <= range_err_s;
      end
      if (capture_s) begin
        rdata_r <= bus_rsp_payload;
      end
      if (timeout_s) begin
        error_r <= 1'b1;
        fault_r <= 1'b1;
      end
    end
  end

  // Outputs are state decodes, forced low while reset is asserted
  assign rsp_valid_s   = (state_r == RESPOND) && !reset;
  assign cpu_req_ready = (state_r == IDLE) && !reset;
  assign bus_req_valid = (state_r == ISSUE) && !reset;
  assign bus_req_pkt   = reset ? '0 : pkt_r;
  assign cpu_rsp_valid = rsp_valid_s;
  assign cpu_rsp_rdata = rsp_valid_s ? rdata_r : 64'd0;
  assign cpu_rsp_error = rsp_valid_s && error_r;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// Scoreboard bench for memory_bus_initiator: expected completions are queued
// when a request is handshaken and compared when cpu_rsp_valid pulses.
module tb_memory_bus_initiator;
  import memory_bus_initiator_pkg::*;

  localparam source_id_t SRC = 4'd5;
  localparam phys_memory_address_t END_ADDR = END_MEMORY_ADDRESS;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_write;
  phys_memory_address_t cpu_req_addr;
  bus_packet_payload_t  cpu_req_wdata;
  logic                 cpu_rsp_valid;
  bus_packet_payload_t  cpu_rsp_rdata;
  logic                 cpu_rsp_error;
  logic                 bus_req_valid;
  BusPacket             bus_req_pkt;
  logic                 bus_req_accept;
  logic                 bus_rsp_valid;
  bus_packet_payload_t  bus_rsp_payload;
  source_id_t           bus_rsp_dest;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  memory_bus_initiator #(
    .SOURCE_ID     (SRC),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_rsp_valid  (cpu_rsp_valid),
    .cpu_rsp_rdata  (cpu_rsp_rdata),
    .cpu_rsp_error  (cpu_rsp_error),
    .bus_req_valid  (bus_req_valid),
    .bus_req_pkt    (bus_req_pkt),
    .bus_req_accept (bus_req_accept),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rsp_payload(bus_rsp_payload),
    .bus_rsp_dest   (bus_rsp_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request in the current cycle (cycle 0) and advance to cycle 1
  task automatic send_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    tick();
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (cpu_rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (cpu_rsp_valid !== 1'b1) n = -1;
  endtask

  function automatic BusPacket mkpkt(input logic wr, input logic [63:0] addr, input logic [63:0] pl);
    BusPacket p;
    p.packet_type = wr ? bus_write_data : bus_read_data;
    p.address     = addr;
    p.payload     = pl;
    p.source      = SRC;
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (cpu_req_ready !== 1'b0 || bus_req_valid !== 1'b0 || cpu_rsp_valid !== 1'b0 ||
        cpu_rsp_error !== 1'b0 || cpu_rsp_rdata !== 64'd0 || bus_req_pkt !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got ready=%b bv=%b rv=%b pkt=%h want all 0",
               cpu_req_ready, bus_req_valid, cpu_rsp_valid, bus_req_pkt);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cpu_req_ready !== 1'b1 || bus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got ready=%b bv=%b want 1/0", cpu_req_ready, bus_req_valid);
    end
  endtask

  task automatic test_write();
    BusPacket p;
    p = mkpkt(1'b1, 64'h100, 64'h1122334455667788);
    exp_q.push_back('{64'd0, 1'b0});
    send_req(1'b1, 64'h100, 64'h1122334455667788);
    bus_req_accept = 1'b1;
    n_cmp++;
    if (bus_req_valid !== 1'b1 || bus_req_pkt !== p || cpu_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL write_pkt got v=%b pkt=%h want 1 %h", bus_req_valid, bus_req_pkt, p);
    end
    tick();
    bus_req_accept = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== e.rdata || cpu_rsp_error !== e.err) begin
      n_bad++;
      $display("FAIL write_rsp got v=%b d=%h e=%b want 1 %h %b",
               cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_error, e.rdata, e.err);
    end
    tick();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1 || bus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL write_idle got rv=%b ready=%b want 0 1", cpu_rsp_valid, cpu_req_ready);
    end
  endtask

  task automatic test_read();
    BusPacket p;
    p = mkpkt(1'b0, 64'h100, 64'd0);
    exp_q.push_back('{64'hDEADBEEF, 1'b0});
    send_req(1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_req_accept = 1'b1;
    n_cmp++;
    if (bus_req_valid !== 1'b1 || bus_req_pkt !== p) begin
      n_bad++;
      $display("FAIL read_pkt got v=%b pkt=%h want 1 %h", bus_req_valid, bus_req_pkt, p);
    end
    tick();
    bus_req_accept  = 1'b0;
    bus_rsp_valid   = 1'b1;
    bus_rsp_payload = 64'hDEADBEEF;
    bus_rsp_dest    = SRC;
    n_cmp++;
    if (cpu_rsp_valid !== 1'b0 || bus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_cycle2 got rv=%b bv=%b want 0 0", cpu_rsp_valid, bus_req_valid);
    end
    tick();
    bus_rsp_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== e.rdata || cpu_rsp_error !== e.err) begin
      n_bad++;
      $display("FAIL read_rsp got v=%b d=%h e=%b want 1 %h %b",
               cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_error, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_stall_filter();
    BusPacket p;
    int n;
    p = mkpkt(1'b0, 64'h2000, 64'd0);
    exp_q.push_back('{64'h0000_600D_CAFE_F00D, 1'b0});
    send_req(1'b0, 64'h2000, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus_req_valid !== 1'b1 || bus_req_pkt !== p || cpu_req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d got v=%b rdy=%b pkt=%h want 1 0 %h",
                 i, bus_req_valid, cpu_req_ready, bus_req_pkt, p);
      end
      tick();
    end
    bus_req_accept = 1'b1;
    tick();
    bus_req_accept  = 1'b0;
    bus_rsp_valid   = 1'b1;
    bus_rsp_payload = 64'hBAD0_BAD0_BAD0_BAD0;
    bus_rsp_dest    = SRC + 4'd1;
    tick();
    bus_rsp_valid = 1'b0;
    tick();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_foreign_rsp got rv=%b want 0", cpu_rsp_valid);
    end
    bus_rsp_valid   = 1'b1;
    bus_rsp_payload = 64'h0000_600D_CAFE_F00D;
    bus_rsp_dest    = SRC;
    tick();
    bus_rsp_valid = 1'b0;
    wait_rsp(4, n);
    e = exp_q.pop_front();
    n_cmp++;
    if (n != 0 || cpu_rsp_rdata !== e.rdata || cpu_rsp_error !== e.err) begin
      n_bad++;
      $display("FAIL stall_match_rsp got delay=%0d d=%h e=%b want 0 %h %b",
               n, cpu_rsp_rdata, cpu_rsp_error, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_range();
    exp_q.push_back('{64'd0, 1'b1});
    send_req(1'b0, END_ADDR - 64'd7, 64'd0);
    e = exp_q.pop_front();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== e.err || cpu_rsp_rdata !== e.rdata ||
        bus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL range_err got v=%b e=%b d=%h bv=%b want 1 1 0 0",
               cpu_rsp_valid, cpu_rsp_error, cpu_rsp_rdata, bus_req_valid);
    end
    tick();
    n_cmp++;
    if (cpu_req_ready !== 1'b1 || bus_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL range_idle got ready=%b bv=%b want 1 0", cpu_req_ready, bus_req_valid);
    end
    // Last legal address: must go out on the bus
    exp_q.push_back('{64'd0, 1'b0});
    send_req(1'b1, END_ADDR - 64'd8, 64'h55);
    n_cmp++;
    if (bus_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL range_edge got bv=%b rv=%b want 1 0", bus_req_valid, cpu_rsp_valid);
    end
    bus_req_accept = 1'b1;
    tick();
    bus_req_accept = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== e.err) begin
      n_bad++;
      $display("FAIL range_edge_rsp got v=%b e=%b want 1 %b", cpu_rsp_valid, cpu_rsp_error, e.err);
    end
    tick();
  endtask

  task automatic test_timeout_race();
    exp_q.push_back('{64'h0123_4567_89AB_CDEF, 1'b0});
    send_req(1'b0, 64'h300, 64'd0);
    bus_req_accept = 1'b1;
    tick();
    bus_req_accept = 1'b0;
    tick();
    tick();
    tick();
    bus_rsp_valid   = 1'b1;
    bus_rsp_payload = 64'h0123_4567_89AB_CDEF;
    bus_rsp_dest    = SRC;
    tick();
    bus_rsp_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== e.rdata || cpu_rsp_error !== e.err) begin
      n_bad++;
      $display("FAIL race_rsp got v=%b d=%h e=%b want 1 %h %b",
               cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_error, e.rdata, e.err);
    end
    tick();
    n_cmp++;
    if (cpu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL race_no_fault got ready=%b want 1", cpu_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    send_req(1'b1, 64'h400, 64'h77);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus_req_valid !== 1'b0 || bus_req_pkt !== '0) begin
      n_bad++;
      $display("FAIL reset_issue got bv=%b pkt=%h want 0 0", bus_req_valid, bus_req_pkt);
    end
    tick();
    reset = 1'b0;
    send_req(1'b0, 64'h408, 64'd0);
    bus_req_accept = 1'b1;
    tick();
    bus_req_accept = 1'b0;
    reset = 1'b1;
    tick();
    reset           = 1'b0;
    bus_rsp_valid   = 1'b1;
    bus_rsp_payload = 64'hAAAA;
    bus_rsp_dest    = SRC;
    tick();
    bus_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_wait%0d got rv=%b ready=%b want 0 1", i, cpu_rsp_valid, cpu_req_ready);
      end
      tick();
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    exp_q.push_back('{64'd0, 1'b1});
    send_req(1'b0, 64'h500, 64'd0);
    bus_req_accept = 1'b1;
    tick();
    bus_req_accept = 1'b0;
    wait_rsp(10, n);
    e = exp_q.pop_front();
    n_cmp++;
    if (n != 4 || cpu_rsp_error !== e.err || cpu_rsp_rdata !== e.rdata) begin
      n_bad++;
      $display("FAIL timeout_rsp got delay=%0d e=%b d=%h want 4 1 0", n, cpu_rsp_error, cpu_rsp_rdata);
    end
    tick();
    cpu_req_valid   = 1'b1;
    bus_rsp_valid   = 1'b1;
    bus_rsp_dest    = SRC;
    bus_rsp_payload = 64'h1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cpu_req_ready !== 1'b0 || bus_req_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_sticky%0d got ready=%b bv=%b rv=%b want 0 0 0",
                 i, cpu_req_ready, bus_req_valid, cpu_rsp_valid);
      end
      tick();
    end
    cpu_req_valid = 1'b0;
    bus_rsp_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cpu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_reset_exit got ready=%b want 1", cpu_req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    cpu_req_valid   = 1'b0;
    cpu_req_write   = 1'b0;
    cpu_req_addr    = 64'd0;
    cpu_req_wdata   = 64'd0;
    bus_req_accept  = 1'b0;
    bus_rsp_valid   = 1'b0;
    bus_rsp_payload = 64'd0;
    bus_rsp_dest    = 4'd0;
    test_reset();
    test_write();
    test_read();
    test_stall_filter();
    test_range();
    test_timeout_race();
    test_reset_mid();
    test_timeout_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_initiator.md
# memory_bus_initiator

CPU-side master of the memory bus: accepts one load/store at a time from a core or cache, formats it as a `BusPacket`, and issues it to the DRAM responder. It then returns read data, or a write completion, to the requester. It performs the address range check, drops responses addressed to other sources, and bounds read latency with a timeout that leaves the block in a sticky fault state.

## Interface
Parameters:
- `SOURCE_ID`, 0, value placed in `pkt.source`; only responses with matching destination are accepted
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent waiting for a read response (≥ 2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `cpu_req_valid`  in  1  request present
- `cpu_req_ready`  out  1  block can accept a request
- `cpu_req_write`  in  1  1 = store, 0 = load
- `cpu_req_addr`  in  64  byte address
- `cpu_req_wdata`  in  64  store data, little-endian payload
- `cpu_rsp_valid`  out  1  one-cycle completion pulse
- `cpu_rsp_rdata`  out  64  load data, valid with `cpu_rsp_valid`
- `cpu_rsp_error`  out  1  range error or timeout, valid with `cpu_rsp_valid`
- `bus_req_valid`  out  1  packet offered (drives `request_busy`)
- `bus_req_pkt`  out  `BusPacket`  `packet_type`, `address`, `payload`, `source`
- `bus_req_accept`  in  1  responder took the packet this cycle
- `bus_rsp_valid`  in  1  read response present (single-cycle)
- `bus_rsp_payload`  in  64  read data
- `bus_rsp_dest`  in  `source_id_t`  response destination

## Operation
- States: `IDLE`, `ISSUE`, `WAIT_RSP`, `RESPOND`, `FAULT`.
- `IDLE`:
  - `cpu_req_ready` = 1.
  - On `cpu_req_valid`, latch the request.
  - If `addr > END_MEMORY_ADDRESS - 8`, go to `RESPOND` with error. No bus traffic.
  - Otherwise, go to `ISSUE`.
- `ISSUE`:
  - `bus_req_valid` = 1, with `bus_req_pkt` held stable.
  - Type is `bus_write_data` or `bus_read_data`; payload is wdata for writes, 0 for reads.
  - On `bus_req_accept`: a write goes to `RESPOND` (the responder sends no write acknowledgement); a read goes to `WAIT_RSP` and clears the timeout counter.
- `WAIT_RSP`:
  - On `bus_rsp_valid && bus_rsp_dest == SOURCE_ID`, capture the payload and go to `RESPOND`.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES-1`, go to `RESPOND` with error and set the fault flag.
  - If a matching response and timeout expiry occur in the same cycle, the response wins.
- `RESPOND`:
  - `cpu_rsp_valid` = 1 for exactly one cycle.
  - Next state is `FAULT` if the fault flag is set, else `IDLE`.
- `FAULT`:
  - `cpu_req_ready` = 0 and the bus is idle; all bus responses are ignored.
  - Exit only by `reset`.
- Responses arriving outside `WAIT_RSP`, or with a non-matching dest, are dropped silently.

## Timing
- While `reset` is high, and in the cycle after: state = `IDLE`, counter = 0, fault flag = 0.
- During `reset`, all outputs are 0: `cpu_req_ready`, `bus_req_valid`, `cpu_rsp_*`, and `bus_req_pkt`.
- `cpu_req_ready` is a combinational decode of `IDLE`.
- All other outputs are registered or decoded from registered state.
- Cycle numbering below: request handshake = cycle 0.
  - Write: `bus_req_valid` is high from cycle 1. With accept in cycle 1, `cpu_rsp_valid` is at cycle 2 and `IDLE` is at cycle 3.
  - Read: accept in cycle 1, earliest response in cycle 2, `cpu_rsp_valid` at cycle 3.
  - Range error: `cpu_rsp_valid` with error at cycle 1.
  - Timeout: error pulse `TIMEOUT_CYCLES` + 1 cycles after the accept cycle.
- `bus_req_valid` never drops without `bus_req_accept`, except on `reset`.
- Reset mid-transaction:
  - The transaction is abandoned and no CPU response is produced.
  - `bus_req_valid` is 0 from the reset cycle.
- `cpu_rsp_rdata` = 0 on writes and error responses.

## Structure
- Shared bus package holds:
  - `bus_packet_type_t` (`bus_read_data`, `bus_write_data`)
  - `BusPacket`
  - `bus_packet_payload_t`
  - `source_id_t`
  - `phys_memory_address_t`
  - `END_MEMORY_ADDRESS`
- The state enum is local to this block.
- One sub-module: `bus_timeout_counter`, with clear, enable, and expired outputs, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Store `0x100` / `0x1122334455667788`, accept in cycle 1 -> `bus_req_pkt` = {write, `0x100`, payload, `SOURCE_ID`}; `cpu_rsp_valid` at cycle 2, error 0.
- Load `0x100`, response in cycle 2 with payload `0xDEADBEEF`, dest = `SOURCE_ID` -> `cpu_rsp_rdata` = `0xDEADBEEF` at cycle 3.
- Load with `bus_req_accept` held low 5 cycles -> `bus_req_pkt` stable throughout, `cpu_req_ready` = 0; then a response with dest = `SOURCE_ID`+1, later a matching one -> only the matching response is returned.
- Load at `END_MEMORY_ADDRESS - 7` -> error pulse at cycle 1, `bus_req_valid` never asserted; a following request is accepted.
- `TIMEOUT_CYCLES` = 4, no response -> error pulse 5 cycles after accept, then `cpu_req_ready` stays 0 until `reset`. Second run: response in the expiry cycle -> valid data, no fault.
- Reset in `WAIT_RSP`, then a late matching response -> no `cpu_rsp_valid`, block in `IDLE`.
